division_datapath: RTL and testbench
====================================

Name: division_datapath

Overview:
- Datapath half of the repeated-subtraction divider; the responder to the existing 4-state division controller.
- Consumes the controller strobes `ld` (load operands), `ld2` (compare) and `cng` (subtract/count).
- Returns the `upd` continue/finish indication that drives the controller's state-1 branch.
- Holds dividend remainder, divisor and quotient registers; flags completion and divide-by-zero.

Parameters:
- WIDTH, 8, operand/result width in bits (min 2).

Ports:
- clk  in  1  system clock; all registers update on posedge.
- rst  in  1  asynchronous, active-low reset.
- ld  in  1  load strobe: capture a_in/b_in, clear quotient.
- ld2  in  1  compare strobe: evaluate remainder >= divisor into upd.
- cng  in  1  change strobe: subtract divisor from remainder, increment quotient.
- a_in  in  WIDTH  dividend.
- b_in  in  WIDTH  divisor.
- upd  out  1  registered; 1 = another subtraction required.
- quot  out  WIDTH  quotient register.
- rem  out  WIDTH  remainder register.
- done  out  1  registered; division complete, sticky until next ld.
- dz  out  1  registered; divisor was zero at last ld.

Behaviour:
- Reset (rst=0, async): R, D, Q = 0; upd, done, dz = 0. Reset release has no other side effect; a reset mid-division abandons it, and nothing resumes until the next ld.
- Strobe priority when several are high on one posedge: ld > cng > ld2. Lower-priority strobes are ignored that cycle.
- ld:
  - R <= a_in; D <= b_in; Q <= 0; upd <= 0; done <= 0.
  - dz <= (b_in == 0).
- ld2 (no ld/cng):
  - If D != 0 and R >= D (unsigned, full WIDTH): upd <= 1, done unchanged.
  - Else: upd <= 0, done <= 1.
  - R, D, Q unchanged. Repeated ld2 with no cng gives the same result (idempotent).
- cng (no ld):
  - If upd == 1: R <= R - D; Q <= Q + 1; upd <= 0, so exactly one subtraction happens per compare.
  - If upd == 0: no register changes (guards against stray cng).
- Arithmetic:
  - Subtraction never underflows because it is gated by R >= D, which was verified at the preceding ld2 and cannot change in between.
  - Q cannot exceed 2^WIDTH-1 since D >= 1; no wrap handling is required. Q+1 is computed at WIDTH bits.
- Timing vs controller:
  - upd is a posedge register. It is stable before the controller's negedge state decision, so the controller sees the result of the ld2 sampled at the same posedge.
  - Latency: ld2 -> upd valid 1 clock edge; cng -> R/Q updated 1 edge.
- Completion:
  - done rises on the ld2 that finds R < D, or D == 0.
  - At that point quot = floor(a/b) and rem = a mod b.
  - If dz=1: quot=0, rem=a_in, done=1 after first ld2.
- No strobe asserted: all registers hold.
- Outputs quot/rem are direct register outputs (no combinational path from inputs).

Test Plan:
- rst low, then high; ld a=13, b=4; run controller sequence -> exactly 3 cng-with-upd cycles; final upd=0, done=1, quot=3, rem=1.
- ld a=3, b=5; ld2 -> upd=0, done=1 on first compare, quot=0, rem=3, no subtraction.
- ld a=7, b=0 -> dz=1; ld2 -> upd=0, done=1, quot=0, rem=7; subsequent cng leaves all values unchanged.
- ld a=255, b=1 (WIDTH=8) -> 255 iterations; quot=255, rem=0, no wrap; done=1.
- ld a=20, b=3; after 2 iterations (quot=2, rem=14) drive rst low mid-cycle -> quot, rem, upd, done, dz = 0 immediately (async); then new ld a=9, b=9 -> quot=1, rem=0.
- Stray and simultaneous strobes:
  - ld a=10, b=2, then ld2 (upd=1); cng+ld2 same edge -> cng wins, rem=8, quot=1, upd=0.
  - Second cng with no ld2 -> no change.
  - ld with cng same edge -> load wins, quot=0.

Source files
------------

// File: rtl/division_datapath.sv
// division_datapath: the datapath that works with the repeated-subtraction
// division controller.
// It holds the remainder (R), divisor (D) and quotient (Q) registers.
// The controller strobes ld / ld2 / cng drive it. It returns upd, which
// tells the controller whether another subtraction step is needed.
// All outputs come straight from registers.
module division_datapath #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             ld2,
    input  logic             cng,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             upd,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             done,
    output logic             dz
);

    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH-1:0] q_reg;
    logic             upd_reg;
    logic             done_reg;
    logic             dz_reg;

    // The compare result is only meaningful for a non-zero divisor.
    // A zero divisor always ends the division.
    logic             step_ok;
    assign step_ok = (d_reg != '0) && (r_reg >= d_reg);

    // Register update. Strobe priority is ld > cng > ld2.
    // A cng only subtracts if the last compare asked for it. Clearing upd
    // afterwards limits each compare to exactly one subtraction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_reg    <= '0;
            d_reg    <= '0;
            q_reg    <= '0;
            upd_reg  <= 1'b0;
            done_reg <= 1'b0;
            dz_reg   <= 1'b0;
        end else if (ld) begin
            r_reg    <= a_in;
            d_reg    <= b_in;
            q_reg    <= '0;
            upd_reg  <= 1'b0;
            done_reg <= 1'b0;
            dz_reg   <= (b_in == '0);
        end else if (cng) begin
            if (upd_reg) begin
                // No underflow here: R >= D was confirmed by the preceding compare.
                r_reg   <= r_reg - d_reg;
                q_reg   <= q_reg + WIDTH'(1);
                upd_reg <= 1'b0;
            end
        end else if (ld2) begin
            if (step_ok) begin
                upd_reg <= 1'b1;
            end else begin
                upd_reg  <= 1'b0;
                done_reg <= 1'b1;
            end
        end
    end

    assign upd  = upd_reg;
    assign quot = q_reg;
    assign rem  = r_reg;
    assign done = done_reg;
    assign dz   = dz_reg;

endmodule

// File: tb/tb_division_datapath.sv
// tb_division_datapath: runs directed vectors through division_datapath.
// Every expected value below was worked out by hand.
module tb_division_datapath;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ld  = 1'b0;
    logic             ld2 = 1'b0;
    logic             cng = 1'b0;
    logic [WIDTH-1:0] a_in = '0;
    logic [WIDTH-1:0] b_in = '0;
    logic             upd;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;
    logic             done;
    logic             dz;

    int checks = 0;
    int errors = 0;
    int iters;

    division_datapath #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .ld   (ld),
        .ld2  (ld2),
        .cng  (cng),
        .a_in (a_in),
        .b_in (b_in),
        .upd  (upd),
        .quot (quot),
        .rem  (rem),
        .done (done),
        .dz   (dz)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Check all outputs at once.
    task automatic chk_all(input string tag, input logic [31:0] e_q, input logic [31:0] e_r,
                           input logic e_upd, input logic e_done, input logic e_dz);
        chk({tag, ".quot"}, 32'(quot), e_q);
        chk({tag, ".rem"},  32'(rem),  e_r);
        chk({tag, ".upd"},  32'(upd),  32'(e_upd));
        chk({tag, ".done"}, 32'(done), 32'(e_done));
        chk({tag, ".dz"},   32'(dz),   32'(e_dz));
        $display("txn %s: quot=%0d rem=%0d upd=%0d done=%0d dz=%0d", tag, quot, rem, upd, done, dz);
    endtask

    // Apply the given strobes across one posedge, then sample 1 time unit after it.
    task automatic step(input logic s_ld, input logic s_ld2, input logic s_cng,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        ld = s_ld; ld2 = s_ld2; cng = s_cng; a_in = a; b_in = b;
        @(posedge clk);
        #1;
        ld = 1'b0; ld2 = 1'b0; cng = 1'b0;
    endtask

    // Act as the controller: compare, then subtract while upd is set.
    // The loop is bounded; hitting the bound counts as a failure.
    task automatic run_div(output int n);
        n = 0;
        for (int k = 0; k < 400; k++) begin
            step(0, 1, 0, '0, '0);
            if (!upd) return;
            step(0, 0, 1, '0, '0);
            n++;
        end
        checks++;
        errors++;
        $error("FAIL run_div_timeout observed %0d expected <400 iterations", n);
    endtask

    initial begin
        // Reset is asserted asynchronously, away from any clock edge.
        #2 rst = 1'b0;
        #1;
        chk_all("reset_async", 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        step(0, 0, 0, '0, '0);
        chk_all("reset_release", 0, 0, 0, 0, 0);

        // 13 / 4 = 3 rem 1. First check idempotent compares.
        step(1, 0, 0, 8'd13, 8'd4);
        chk_all("ld13_4", 0, 13, 0, 0, 0);
        step(0, 1, 0, '0, '0);
        chk_all("ld13_4_cmp1", 0, 13, 1, 0, 0);
        step(0, 1, 0, '0, '0);
        chk_all("ld13_4_cmp_again", 0, 13, 1, 0, 0);
        step(0, 0, 1, '0, '0);
        chk_all("ld13_4_sub1", 1, 9, 0, 0, 0);
        run_div(iters);
        chk("div13_4.iters", 32'(iters), 2);
        chk_all("div13_4_end", 3, 1, 0, 1, 0);
        step(0, 0, 0, '0, '0);
        chk_all("div13_4_hold", 3, 1, 0, 1, 0);
        step(0, 1, 0, '0, '0);
        chk_all("div13_4_done_sticky", 3, 1, 0, 1, 0);

        // 3 / 5: finishes on the first compare.
        step(1, 0, 0, 8'd3, 8'd5);
        run_div(iters);
        chk("div3_5.iters", 32'(iters), 0);
        chk_all("div3_5_end", 0, 3, 0, 1, 0);

        // 7 / 0: divide by zero.
        step(1, 0, 0, 8'd7, 8'd0);
        chk_all("div7_0_ld", 0, 7, 0, 0, 1);
        step(0, 1, 0, '0, '0);
        chk_all("div7_0_cmp", 0, 7, 0, 1, 1);
        step(0, 0, 1, '0, '0);
        chk_all("div7_0_stray_cng", 0, 7, 0, 1, 1);

        // Async reset clears dz and the registers immediately.
        #2 rst = 1'b0;
        #1;
        chk_all("div7_0_reset", 0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        @(posedge clk); #1;

        // 255 / 1: full-range quotient with no wrap.
        step(1, 0, 0, 8'd255, 8'd1);
        run_div(iters);
        chk("div255_1.iters", 32'(iters), 255);
        chk_all("div255_1_end", 255, 0, 0, 1, 0);

        // 20 / 3, abandoned by a reset after two subtractions.
        step(1, 0, 0, 8'd20, 8'd3);
        step(0, 1, 0, '0, '0);
        step(0, 0, 1, '0, '0);
        step(0, 1, 0, '0, '0);
        step(0, 0, 1, '0, '0);
        chk_all("div20_3_mid", 2, 14, 0, 0, 0);
        step(0, 1, 0, '0, '0);
        chk_all("div20_3_cmp3", 2, 14, 1, 0, 0);
        #2 rst = 1'b0;
        #1;
        chk_all("div20_3_reset", 0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        step(0, 0, 1, '0, '0);
        chk_all("after_reset_no_resume", 0, 0, 0, 0, 0);
        step(1, 0, 0, 8'd9, 8'd9);
        run_div(iters);
        chk("div9_9.iters", 32'(iters), 1);
        chk_all("div9_9_end", 1, 0, 0, 1, 0);

        // Strobe priority tests.
        step(1, 0, 0, 8'd10, 8'd2);
        step(0, 1, 0, '0, '0);
        chk_all("div10_2_cmp", 0, 10, 1, 0, 0);
        step(0, 1, 1, '0, '0);
        chk_all("cng_beats_ld2", 1, 8, 0, 0, 0);
        step(0, 0, 1, '0, '0);
        chk_all("second_cng_ignored", 1, 8, 0, 0, 0);
        step(0, 1, 0, '0, '0);
        chk_all("div10_2_cmp2", 1, 8, 1, 0, 0);
        step(1, 0, 1, 8'd50, 8'd7);
        chk_all("ld_beats_cng", 0, 50, 0, 0, 0);
        step(1, 1, 0, 8'd6, 8'd2);
        chk_all("ld_beats_ld2", 0, 6, 0, 0, 0);
        run_div(iters);
        chk("div6_2.iters", 32'(iters), 3);
        chk_all("div6_2_end", 3, 0, 0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net: if the sequence above stalls, stop the run.
    initial begin
        #200000;
        $display("FAIL global_timeout observed stall expected completion");
        $fatal(1, "timeout");
    end

endmodule
